// File: rtl/div_unit.sv
// div_unit: iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip CALC and finish in one cycle.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_divu,
  input  logic             op_rem,
  input  logic             op_remu,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] dvd, rem, dsr, sp_val;
  logic neg_q, neg_r, is_rem_r, ok_r, sp_r;
  logic [3:0] ops;
  logic ok, sgn, is_rem, a_neg, b_neg, dz, ovf, sp, accept;
  logic [WIDTH-1:0] abs_a, abs_b, sp_in, q_nxt, r_nxt, fin;
  logic [WIDTH:0] diff;
  always_comb begin
    ops = {op_div, op_divu, op_rem, op_remu};
    ok = (ops != 4'd0) && ((ops & (ops - 4'd1)) == 4'd0);
    sgn = op_div | op_rem;
    is_rem = op_rem | op_remu;
    a_neg = sgn & operand_a[WIDTH-1];
    b_neg = sgn & operand_b[WIDTH-1];
    abs_a = a_neg ? -operand_a : operand_a;
    abs_b = b_neg ? -operand_b : operand_b;
    dz = operand_b == '0;
    ovf = sgn && operand_a == {1'b1, {(WIDTH-1){1'b0}}} && operand_b == '1;
    sp = dz | ovf;
    sp_in = dz ? (is_rem ? operand_a : '1) : (is_rem ? '0 : operand_a);
    accept = start && state != CALC;
    // remainder needs WIDTH+1 bits after the shift when the divisor uses the top bit
    diff = {rem, dvd[WIDTH-1]} - {1'b0, dsr};
    q_nxt = {dvd[WIDTH-2:0], ~diff[WIDTH]};
    r_nxt = diff[WIDTH] ? {rem[WIDTH-2:0], dvd[WIDTH-1]} : diff[WIDTH-1:0];
    fin = !ok_r ? '0 : sp_r ? sp_val : is_rem_r ? (neg_r ? -r_nxt : r_nxt) : (neg_q ? -q_nxt : q_nxt);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      dvd <= '0;
      rem <= '0;
      dsr <= '0;
      sp_val <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      is_rem_r <= 1'b0;
      ok_r <= 1'b0;
      sp_r <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        dvd <= abs_a;
        rem <= '0;
        dsr <= abs_b;
        cnt <= '0;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        is_rem_r <= is_rem;
        ok_r <= ok;
        sp_r <= sp;
        sp_val <= sp_in;
`ifdef DIV_EARLY_OUT_EN
        if (sp) begin
          state <= DONE;
          done <= 1'b1;
          result <= ok ? sp_in : '0;
        end else begin
          state <= CALC;
          busy <= 1'b1;
        end
`else
        state <= CALC;
        busy <= 1'b1;
`endif
      end else if (state == CALC) begin
        dvd <= q_nxt;
        rem <= r_nxt;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          result <= fin;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule
